// File: rtl/core_wbu_top.sv
// Write-back stage: accepts executed instructions, drives the GPR write port,
// performs CSR reads for CSR instructions, and counts retired instructions.
module core_wbu_top #(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wbu_rx_valid,
    output logic                 wbu_rx_ready,
    input  logic [31:0]          wbu_rx_exu_res,
    input  logic [31:0]          wbu_rx_pc,
    input  logic [31:0]          wbu_rx_pc_seq,
    input  logic [31:0]          wbu_rx_imme,
    input  logic                 wbu_rx_alu_valid,
    input  logic                 wbu_rx_imme_valid,
    input  logic                 wbu_rx_pc_valid,
    input  logic                 wbu_rx_pc_seq_valid,
    input  logic                 wbu_rx_csr_valid,
    input  logic [4:0]           wbu_rx_rd_idx,
    output logic                 wbu_csr_req_valid,
    input  logic                 wbu_csr_req_ready,
    output logic [11:0]          wbu_csr_req_addr,
    input  logic                 wbu_csr_rsp_valid,
    input  logic [31:0]          wbu_csr_rsp_data,
    output logic                 wbu_gpr_wr_en,
    output logic [4:0]           wbu_gpr_wr_idx,
    output logic [31:0]          wbu_gpr_wr_data,
    output logic [INSTRET_W-1:0] wbu_instret,
    output logic                 wbu_sel_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CSR_REQ,
        S_CSR_RSP
    } state_t;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [4:0]  csr_rd;
    logic        acc;
    logic [2:0]  flag_cnt;
    logic        has_src;
    logic [31:0] src_data;

    assign wbu_rx_ready = (state == S_IDLE);
    assign acc          = wbu_rx_valid && wbu_rx_ready;

    assign flag_cnt = {2'b00, wbu_rx_alu_valid} + {2'b00, wbu_rx_imme_valid}
                    + {2'b00, wbu_rx_pc_valid} + {2'b00, wbu_rx_pc_seq_valid}
                    + {2'b00, wbu_rx_csr_valid};

    // Non-CSR source mux; CSR takes priority and is handled by the FSM instead.
    always_comb begin
        has_src  = 1'b1;
        src_data = 32'h0;
        if (wbu_rx_alu_valid)         src_data = wbu_rx_exu_res;
        else if (wbu_rx_imme_valid)   src_data = wbu_rx_imme;
        else if (wbu_rx_pc_valid)     src_data = wbu_rx_pc;
        else if (wbu_rx_pc_seq_valid) src_data = wbu_rx_pc_seq;
        else                          has_src  = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= S_IDLE;
            csr_rd            <= 5'd0;
            wbu_csr_req_valid <= 1'b0;
            wbu_csr_req_addr  <= 12'h0;
            wbu_gpr_wr_en     <= 1'b0;
            wbu_gpr_wr_idx    <= 5'd0;
            wbu_gpr_wr_data   <= 32'h0;
            wbu_instret       <= '0;
            wbu_sel_err       <= 1'b0;
        end else begin
            wbu_gpr_wr_en <= 1'b0;
            if (acc && flag_cnt > 3'd1) begin
                wbu_sel_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (acc) begin
                        if (wbu_rx_csr_valid) begin
                            csr_rd            <= wbu_rx_rd_idx;
                            wbu_csr_req_addr  <= wbu_rx_imme[11:0];
                            wbu_csr_req_valid <= 1'b1;
                            state             <= S_CSR_REQ;
                        end else begin
                            wbu_instret <= wbu_instret + INSTRET_ONE;
                            if (has_src && wbu_rx_rd_idx != 5'd0) begin
                                wbu_gpr_wr_en   <= 1'b1;
                                wbu_gpr_wr_idx  <= wbu_rx_rd_idx;
                                wbu_gpr_wr_data <= src_data;
                            end
                        end
                    end
                end
                S_CSR_REQ: begin
                    if (wbu_csr_req_ready) begin
                        wbu_csr_req_valid <= 1'b0;
                        state             <= S_CSR_RSP;
                    end
                end
                S_CSR_RSP: begin
                    if (wbu_csr_rsp_valid) begin
                        wbu_instret <= wbu_instret + INSTRET_ONE;
                        if (csr_rd != 5'd0) begin
                            wbu_gpr_wr_en   <= 1'b1;
                            wbu_gpr_wr_idx  <= csr_rd;
                            wbu_gpr_wr_data <= wbu_csr_rsp_data;
                        end
                        state <= S_IDLE;
                    end
                end
                default: begin
                    wbu_csr_req_valid <= 1'b0;
                    state             <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_wbu_top.sv
// Directed self-checking bench for core_wbu_top: inputs driven and outputs
// sampled on the falling edge, expected values hand-computed.
module tb_core_wbu_top;

    logic        clk;
    logic        rstn;
    logic        wbu_rx_valid;
    logic        wbu_rx_ready;
    logic [31:0] wbu_rx_exu_res;
    logic [31:0] wbu_rx_pc;
    logic [31:0] wbu_rx_pc_seq;
    logic [31:0] wbu_rx_imme;
    logic        wbu_rx_alu_valid;
    logic        wbu_rx_imme_valid;
    logic        wbu_rx_pc_valid;
    logic        wbu_rx_pc_seq_valid;
    logic        wbu_rx_csr_valid;
    logic [4:0]  wbu_rx_rd_idx;
    logic        wbu_csr_req_valid;
    logic        wbu_csr_req_ready;
    logic [11:0] wbu_csr_req_addr;
    logic        wbu_csr_rsp_valid;
    logic [31:0] wbu_csr_rsp_data;
    logic        wbu_gpr_wr_en;
    logic [4:0]  wbu_gpr_wr_idx;
    logic [31:0] wbu_gpr_wr_data;
    logic [63:0] wbu_instret;
    logic        wbu_sel_err;

    int checkCount = 0;
    int passCount  = 0;

    core_wbu_top #(.INSTRET_W(64)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .wbu_rx_valid        (wbu_rx_valid),
        .wbu_rx_ready        (wbu_rx_ready),
        .wbu_rx_exu_res      (wbu_rx_exu_res),
        .wbu_rx_pc           (wbu_rx_pc),
        .wbu_rx_pc_seq       (wbu_rx_pc_seq),
        .wbu_rx_imme         (wbu_rx_imme),
        .wbu_rx_alu_valid    (wbu_rx_alu_valid),
        .wbu_rx_imme_valid   (wbu_rx_imme_valid),
        .wbu_rx_pc_valid     (wbu_rx_pc_valid),
        .wbu_rx_pc_seq_valid (wbu_rx_pc_seq_valid),
        .wbu_rx_csr_valid    (wbu_rx_csr_valid),
        .wbu_rx_rd_idx       (wbu_rx_rd_idx),
        .wbu_csr_req_valid   (wbu_csr_req_valid),
        .wbu_csr_req_ready   (wbu_csr_req_ready),
        .wbu_csr_req_addr    (wbu_csr_req_addr),
        .wbu_csr_rsp_valid   (wbu_csr_rsp_valid),
        .wbu_csr_rsp_data    (wbu_csr_rsp_data),
        .wbu_gpr_wr_en       (wbu_gpr_wr_en),
        .wbu_gpr_wr_idx      (wbu_gpr_wr_idx),
        .wbu_gpr_wr_data     (wbu_gpr_wr_data),
        .wbu_instret         (wbu_instret),
        .wbu_sel_err         (wbu_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags order: {csr, alu, imme, pc, pc_seq}
    task automatic applyStimulus(input logic valid, input logic [4:0] flags,
                                 input logic [4:0] rd, input logic [31:0] res,
                                 input logic [31:0] pc, input logic [31:0] pc_seq,
                                 input logic [31:0] imme);
        wbu_rx_valid        = valid;
        wbu_rx_csr_valid    = flags[4];
        wbu_rx_alu_valid    = flags[3];
        wbu_rx_imme_valid   = flags[2];
        wbu_rx_pc_valid     = flags[1];
        wbu_rx_pc_seq_valid = flags[0];
        wbu_rx_rd_idx       = rd;
        wbu_rx_exu_res      = res;
        wbu_rx_pc           = pc;
        wbu_rx_pc_seq       = pc_seq;
        wbu_rx_imme         = imme;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkWrite(input string tag, input logic en, input logic [4:0] idx,
                              input logic [31:0] data, input logic [63:0] instret);
        checkOutput({tag, ".wr_en"}, 64'(wbu_gpr_wr_en), 64'(en));
        checkOutput({tag, ".wr_idx"}, 64'(wbu_gpr_wr_idx), 64'(idx));
        checkOutput({tag, ".wr_data"}, 64'(wbu_gpr_wr_data), 64'(data));
        checkOutput({tag, ".instret"}, wbu_instret, instret);
    endtask

    initial begin
        rstn              = 1'b0;
        wbu_csr_req_ready = 1'b0;
        wbu_csr_rsp_valid = 1'b0;
        wbu_csr_rsp_data  = 32'h0;
        applyStimulus(1'b0, 5'b00000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset state
        #2;
        checkWrite("reset", 1'b0, 5'd0, 32'h0, 64'd0);
        checkOutput("reset.req_valid", 64'(wbu_csr_req_valid), 64'd0);
        checkOutput("reset.req_addr", 64'(wbu_csr_req_addr), 64'd0);
        checkOutput("reset.sel_err", 64'(wbu_sel_err), 64'd0);
        tick();
        tick();
        rstn = 1'b1;
        #1;
        checkOutput("reset.ready", 64'(wbu_rx_ready), 64'd1);

        // Back-to-back ALU
        @(negedge clk);
        applyStimulus(1'b1, 5'b01000, 5'd5, 32'h11, 32'h0, 32'h0, 32'h0);
        tick();
        checkWrite("alu0", 1'b1, 5'd5, 32'h11, 64'd1);
        applyStimulus(1'b1, 5'b01000, 5'd6, 32'h22, 32'h0, 32'h0, 32'h0);
        tick();
        checkWrite("alu1", 1'b1, 5'd6, 32'h22, 64'd2);
        applyStimulus(1'b1, 5'b01000, 5'd7, 32'h33, 32'h0, 32'h0, 32'h0);
        tick();
        checkWrite("alu2", 1'b1, 5'd7, 32'h33, 64'd3);
        checkOutput("alu2.ready", 64'(wbu_rx_ready), 64'd1);
        applyStimulus(1'b0, 5'b01000, 5'd8, 32'h44, 32'h0, 32'h0, 32'h0);
        tick();
        checkWrite("idle0", 1'b0, 5'd7, 32'h33, 64'd3);

        // Source select
        applyStimulus(1'b1, 5'b00100, 5'd3, 32'h1, 32'h2, 32'h3, 32'hABCDE000);
        tick();
        checkWrite("lui", 1'b1, 5'd3, 32'hABCDE000, 64'd4);
        applyStimulus(1'b1, 5'b00010, 5'd10, 32'h1, 32'h80000010, 32'h3, 32'h4);
        tick();
        checkWrite("auipc", 1'b1, 5'd10, 32'h80000010, 64'd5);
        applyStimulus(1'b1, 5'b00001, 5'd1, 32'h1, 32'h2, 32'h80000008, 32'h4);
        tick();
        checkWrite("jal", 1'b1, 5'd1, 32'h80000008, 64'd6);

        // Suppressed writes: x0 target, then no source
        applyStimulus(1'b1, 5'b01000, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
        tick();
        checkWrite("x0", 1'b0, 5'd1, 32'h80000008, 64'd7);
        applyStimulus(1'b1, 5'b00000, 5'd2, 32'h12345678, 32'h0, 32'h0, 32'h0);
        tick();
        checkWrite("branch", 1'b0, 5'd1, 32'h80000008, 64'd8);
        checkOutput("branch.sel_err", 64'(wbu_sel_err), 64'd0);

        // CSR path with delayed req_ready and rsp_valid
        applyStimulus(1'b1, 5'b10000, 5'd9, 32'h0, 32'h0, 32'h0, 32'h00000300);
        tick();
        applyStimulus(1'b0, 5'b00000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("csr.req_valid0", 64'(wbu_csr_req_valid), 64'd1);
        checkOutput("csr.req_addr", 64'(wbu_csr_req_addr), 64'h300);
        checkOutput("csr.ready0", 64'(wbu_rx_ready), 64'd0);
        checkOutput("csr.wr_en0", 64'(wbu_gpr_wr_en), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("csr.req_valid_hold", 64'(wbu_csr_req_valid), 64'd1);
            checkOutput("csr.ready_hold", 64'(wbu_rx_ready), 64'd0);
        end
        wbu_csr_req_ready = 1'b1;
        tick();
        wbu_csr_req_ready = 1'b0;
        checkOutput("csr.req_valid_done", 64'(wbu_csr_req_valid), 64'd0);
        checkOutput("csr.ready_rsp", 64'(wbu_rx_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("csr.ready_wait", 64'(wbu_rx_ready), 64'd0);
            checkOutput("csr.wr_en_wait", 64'(wbu_gpr_wr_en), 64'd0);
            checkOutput("csr.instret_wait", wbu_instret, 64'd8);
        end
        wbu_csr_rsp_valid = 1'b1;
        wbu_csr_rsp_data  = 32'h1800;
        tick();
        checkWrite("csr.wb", 1'b1, 5'd9, 32'h1800, 64'd9);
        checkOutput("csr.ready_back", 64'(wbu_rx_ready), 64'd1);
        // rsp_valid while idle must be ignored
        wbu_csr_rsp_data = 32'hBAD;
        tick();
        wbu_csr_rsp_valid = 1'b0;
        checkWrite("csr.stray_rsp", 1'b0, 5'd9, 32'h1800, 64'd9);

        // Multi-flag: alu wins, sel_err sticky
        applyStimulus(1'b1, 5'b01100, 5'd4, 32'h5, 32'h0, 32'h0, 32'h7);
        tick();
        checkWrite("multi", 1'b1, 5'd4, 32'h5, 64'd10);
        checkOutput("multi.sel_err", 64'(wbu_sel_err), 64'd1);
        applyStimulus(1'b1, 5'b01000, 5'd8, 32'h44, 32'h0, 32'h0, 32'h0);
        tick();
        checkWrite("clean", 1'b1, 5'd8, 32'h44, 64'd11);
        checkOutput("clean.sel_err", 64'(wbu_sel_err), 64'd1);

        // Reset while waiting for the CSR response
        applyStimulus(1'b1, 5'b10000, 5'd12, 32'h0, 32'h0, 32'h0, 32'h00000341);
        tick();
        applyStimulus(1'b0, 5'b00000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("rst.req_addr", 64'(wbu_csr_req_addr), 64'h341);
        wbu_csr_req_ready = 1'b1;
        tick();
        wbu_csr_req_ready = 1'b0;
        checkOutput("rst.in_rsp", 64'(wbu_rx_ready), 64'd0);
        rstn = 1'b0;
        #1;
        checkWrite("rst.asserted", 1'b0, 5'd0, 32'h0, 64'd0);
        checkOutput("rst.req_valid", 64'(wbu_csr_req_valid), 64'd0);
        checkOutput("rst.sel_err", 64'(wbu_sel_err), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("rst.ready", 64'(wbu_rx_ready), 64'd1);
        @(negedge clk);
        wbu_csr_rsp_valid = 1'b1;
        wbu_csr_rsp_data  = 32'hDEAD;
        tick();
        wbu_csr_rsp_valid = 1'b0;
        checkWrite("rst.late_rsp", 1'b0, 5'd0, 32'h0, 64'd0);
        checkOutput("rst.late_ready", 64'(wbu_rx_ready), 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
